// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared operation encodings for the program-counter stage.
//               The instruction decoder in the control unit uses the same
//               constants, so both sides agree on OP values.
//               Encodings 3'b110 and 3'b111 are unused and behave as HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  localparam int c_op_width = 3;

  localparam logic [c_op_width-1:0] OP_HOLD = 3'b000;
  localparam logic [c_op_width-1:0] OP_INC  = 3'b001;
  localparam logic [c_op_width-1:0] OP_JMP  = 3'b010;
  localparam logic [c_op_width-1:0] OP_BR   = 3'b011;
  localparam logic [c_op_width-1:0] OP_CALL = 3'b100;
  localparam logic [c_op_width-1:0] OP_RET  = 3'b101;

endpackage
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_ret_stack
// Description : Parameterised LIFO holding return addresses.
//               A push writes data_in at the current count and increments
//               it; a pop decrements it. data_out always shows the top
//               entry (undefined when empty). The count saturates at 0 and
//               DEPTH; there is no wrap-around.
// Ports       : clk      - clock, rising edge
//               rst_n    - synchronous active-low reset (count only)
//               push     - write data_in on top (ignored when full)
//               pop      - discard top entry (ignored when empty)
//               data_in  - value to push
//               data_out - current top entry
//               count    - number of valid entries, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_can_push;
  logic             w_can_pop;

  // With a power-of-two depth, the low bits of the count address the next
  // free slot. When the stack is full they wrap to 0, which still makes
  // w_rd_idx (count-1) land on the top entry.
  assign w_wr_idx   = r_count[IDX_W-1:0];
  assign w_rd_idx   = w_wr_idx - 1'b1;
  assign w_can_push = (r_count != CNT_W'(DEPTH));
  assign w_can_pop  = (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (push && w_can_push) begin
      r_count <= r_count + 1'b1;
    end else if (pop && w_can_pop) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Entries need no reset: they are only read below the count.
  always_ff @(posedge clk) begin
    if (rst_n && push && w_can_push) begin
      r_mem[w_wr_idx] <= data_in;
    end
  end

  assign data_out = r_mem[w_rd_idx];
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program-counter stage. The PC is a register loaded every
//               enabled cycle with the next address chosen by OP. A small
//               return-address stack supports CALL/RET. Stack overflow or
//               underflow sets a sticky FAULT flag that only reset clears.
//               Optional interrupt support is built when the macro
//               PC_IRQ_EN is defined (adds port irq and parameter
//               IRQ_VECTOR).
// Ports       : clk         - clock, rising edge
//               rst_n       - synchronous active-low reset
//               en          - advance enable, 0 holds all state
//               op          - operation (see pc_pkg)
//               target      - absolute destination for JMP/CALL
//               offset      - signed displacement for BR
//               cond        - branch-taken condition for BR
//               irq         - interrupt request (PC_IRQ_EN only)
//               pc          - registered program counter
//               sp          - number of valid stack entries
//               stack_full  - sp == STACK_DEPTH
//               stack_empty - sp == 0
//               fault       - sticky overflow/underflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    OFS_WIDTH    = 5,
  parameter int                    STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
`ifdef PC_IRQ_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR   = ADDR_WIDTH'(8'hF0)
`endif
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [c_op_width-1:0]          op,
  input  logic [ADDR_WIDTH-1:0]          target,
  input  logic [OFS_WIDTH-1:0]           offset,
  input  logic                           cond,
`ifdef PC_IRQ_EN
  input  logic                           irq,
`endif
  output logic [ADDR_WIDTH-1:0]          pc,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           fault
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_fault;

  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_ofs_ext;
  logic [ADDR_WIDTH-1:0] w_br_pc;
  logic [ADDR_WIDTH-1:0] w_top;
  logic [SP_W-1:0]       w_sp;
  logic                  w_full;
  logic                  w_empty;

  // Result of OP alone, before any interrupt override.
  logic [ADDR_WIDTH-1:0] w_op_pc;
  logic                  w_op_push;
  logic                  w_op_pop;
  logic                  w_op_fault;

  // Final decisions applied when en is high.
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [ADDR_WIDTH-1:0] w_push_data;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fault_set;

  // All sums are naturally modulo 2^ADDR_WIDTH through truncation.
  assign w_pc_inc  = r_pc + 1'b1;
  assign w_ofs_ext = ADDR_WIDTH'($signed(offset));
  assign w_br_pc   = r_pc + w_ofs_ext;

  assign w_full  = (w_sp == SP_W'(STACK_DEPTH));
  assign w_empty = (w_sp == '0);

  always_comb begin
    w_op_pc    = r_pc;
    w_op_push  = 1'b0;
    w_op_pop   = 1'b0;
    w_op_fault = 1'b0;
    case (op)
      OP_INC:  w_op_pc = w_pc_inc;
      OP_JMP:  w_op_pc = target;
      OP_BR:   w_op_pc = cond ? w_br_pc : w_pc_inc;
      OP_CALL: begin
        if (!w_full) begin
          w_op_pc   = target;
          w_op_push = 1'b1;
        end else begin
          w_op_pc    = w_pc_inc;
          w_op_fault = 1'b1;
        end
      end
      OP_RET: begin
        if (!w_empty) begin
          w_op_pc  = w_top;
          w_op_pop = 1'b1;
        end else begin
          w_op_pc    = w_pc_inc;
          w_op_fault = 1'b1;
        end
      end
      default: w_op_pc = r_pc;
    endcase
  end

`ifdef PC_IRQ_EN
  // An accepted interrupt replaces OP entirely: the address OP would have
  // produced becomes the return address and control goes to IRQ_VECTOR.
  // With no room on the stack the interrupt is refused, flagged, and OP
  // runs as usual.
  always_comb begin
    w_pc_next   = w_op_pc;
    w_push      = w_op_push;
    w_pop       = w_op_pop;
    w_fault_set = w_op_fault;
    w_push_data = w_pc_inc;
    if (irq) begin
      if (!w_full) begin
        w_pc_next   = IRQ_VECTOR;
        w_push      = 1'b1;
        w_pop       = 1'b0;
        w_fault_set = 1'b0;
        w_push_data = w_op_pc;
      end else begin
        w_fault_set = 1'b1;
      end
    end
  end
`else
  assign w_pc_next   = w_op_pc;
  assign w_push      = w_op_push;
  assign w_pop       = w_op_pop;
  assign w_fault_set = w_op_fault;
  assign w_push_data = w_pc_inc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_fault <= 1'b0;
    end else if (en) begin
      r_pc <= w_pc_next;
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end
    end
  end

  pc_ret_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (en && w_push),
    .pop      (en && w_pop),
    .data_in  (w_push_data),
    .data_out (w_top),
    .count    (w_sp)
  );

  assign pc          = r_pc;
  assign sp          = w_sp;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed self-checking bench for pc_unit (default
//               parameters). The interrupt scenario is built only when
//               PC_IRQ_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;
  import pc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] op;
  logic [7:0] target;
  logic [4:0] offset;
  logic       cond;
`ifdef PC_IRQ_EN
  logic       irq;
`endif
  logic [7:0] pc;
  logic [2:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       fault;

  int n_tests = 0;
  int n_fail  = 0;

  pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .op          (op),
    .target      (target),
    .offset      (offset),
    .cond        (cond),
`ifdef PC_IRQ_EN
    .irq         (irq),
`endif
    .pc          (pc),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one operation for one clock, then sample 1 time unit after the edge.
  task automatic step(input logic e, input logic [2:0] o, input logic [7:0] t,
                      input logic [4:0] ofs, input logic c);
    en     = e;
    op     = o;
    target = t;
    offset = ofs;
    cond   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] o);
    rst_n = 1'b0;
    step(1'b1, o, 8'h55, 5'd0, 1'b0);
    step(1'b1, o, 8'h55, 5'd0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    op     = OP_HOLD;
    target = '0;
    offset = '0;
    cond   = 1'b0;
`ifdef PC_IRQ_EN
    irq    = 1'b0;
`endif

    // Reset state
    do_reset(OP_INC);
    chk("rst_pc",    pc, 8'h00);
    chk("rst_sp",    sp, 3'd0);
    chk("rst_empty", stack_empty, 1'b1);
    chk("rst_full",  stack_full, 1'b0);
    chk("rst_fault", fault, 1'b0);

    // INC x3
    step(1'b1, OP_INC, 8'h00, 5'd0, 1'b0); chk("inc1", pc, 8'h01);
    step(1'b1, OP_INC, 8'h00, 5'd0, 1'b0); chk("inc2", pc, 8'h02);
    step(1'b1, OP_INC, 8'h00, 5'd0, 1'b0); chk("inc3", pc, 8'h03);
    chk("inc_sp", sp, 3'd0);

    // Branches and INC wrap
    step(1'b1, OP_JMP, 8'h10, 5'd0, 1'b0);      chk("jmp10", pc, 8'h10);
    step(1'b1, OP_BR,  8'h00, 5'b11100, 1'b1);  chk("br_taken", pc, 8'h0C);
    step(1'b1, OP_JMP, 8'h10, 5'd0, 1'b0);
    step(1'b1, OP_BR,  8'h00, 5'b11100, 1'b0);  chk("br_not", pc, 8'h11);
    step(1'b1, OP_JMP, 8'hFF, 5'd0, 1'b0);
    step(1'b1, OP_INC, 8'h00, 5'd0, 1'b0);      chk("inc_wrap", pc, 8'h00);
    step(1'b1, OP_JMP, 8'h02, 5'd0, 1'b0);
    step(1'b1, OP_BR,  8'h00, 5'b11100, 1'b1);  chk("br_wrap", pc, 8'hFE);
    step(1'b1, OP_BR,  8'h00, 5'b00011, 1'b1);  chk("br_pos", pc, 8'h01);
    step(1'b1, OP_HOLD, 8'h77, 5'd0, 1'b1);     chk("hold", pc, 8'h01);
    step(1'b1, 3'b110, 8'h77, 5'd0, 1'b1);      chk("op110", pc, 8'h01);

    // Nested calls
    step(1'b1, OP_JMP,  8'h05, 5'd0, 1'b0);
    step(1'b1, OP_CALL, 8'h40, 5'd0, 1'b0);  chk("call1_pc", pc, 8'h40); chk("call1_sp", sp, 3'd1);
    step(1'b1, OP_INC,  8'h00, 5'd0, 1'b0);  chk("inc41", pc, 8'h41);
    step(1'b1, OP_CALL, 8'h80, 5'd0, 1'b0);  chk("call2_pc", pc, 8'h80); chk("call2_sp", sp, 3'd2);
    step(1'b1, OP_RET,  8'h00, 5'd0, 1'b0);  chk("ret1_pc", pc, 8'h42); chk("ret1_sp", sp, 3'd1);
    step(1'b1, OP_RET,  8'h00, 5'd0, 1'b0);  chk("ret2_pc", pc, 8'h06); chk("ret2_sp", sp, 3'd0);
    chk("nest_fault", fault, 1'b0);

    // Overflow: pushes 07, 11, 12, 13
    step(1'b1, OP_CALL, 8'h10, 5'd0, 1'b0);
    step(1'b1, OP_CALL, 8'h11, 5'd0, 1'b0);
    step(1'b1, OP_CALL, 8'h12, 5'd0, 1'b0);
    step(1'b1, OP_CALL, 8'h13, 5'd0, 1'b0);
    chk("fill_sp", sp, 3'd4);
    chk("fill_full", stack_full, 1'b1);
    chk("fill_empty", stack_empty, 1'b0);
    chk("fill_fault", fault, 1'b0);
    step(1'b1, OP_JMP,  8'h20, 5'd0, 1'b0);
    step(1'b1, OP_CALL, 8'h50, 5'd0, 1'b0);
    chk("ovf_pc", pc, 8'h21); chk("ovf_sp", sp, 3'd4); chk("ovf_fault", fault, 1'b1);
    step(1'b1, OP_RET, 8'h00, 5'd0, 1'b0);
    chk("ovf_ret1_pc", pc, 8'h13); chk("ovf_ret1_sp", sp, 3'd3); chk("fault_sticky1", fault, 1'b1);
    step(1'b1, OP_RET, 8'h00, 5'd0, 1'b0);
    chk("ovf_ret2_pc", pc, 8'h12); chk("fault_sticky2", fault, 1'b1);

    // Reset with a CALL presented: the CALL is discarded
    do_reset(OP_CALL);
    chk("rst2_pc", pc, 8'h00); chk("rst2_sp", sp, 3'd0); chk("rst2_fault", fault, 1'b0);

    // Underflow and stall
    step(1'b1, OP_JMP, 8'h30, 5'd0, 1'b0);
    step(1'b1, OP_RET, 8'h00, 5'd0, 1'b0);
    chk("unf_pc", pc, 8'h31); chk("unf_fault", fault, 1'b1); chk("unf_sp", sp, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, OP_JMP, 8'hAA, 5'd0, 1'b0);
      chk("stall_pc", pc, 8'h31);
    end
    step(1'b0, OP_CALL, 8'hAA, 5'd0, 1'b0);
    chk("stall_call_pc", pc, 8'h31); chk("stall_call_sp", sp, 3'd0);

    // Pushed return address wraps
    step(1'b1, OP_JMP,  8'hFF, 5'd0, 1'b0);
    step(1'b1, OP_CALL, 8'h40, 5'd0, 1'b0);  chk("callwrap_pc", pc, 8'h40);
    step(1'b1, OP_RET,  8'h00, 5'd0, 1'b0);  chk("retwrap_pc", pc, 8'h00);

`ifdef PC_IRQ_EN
    do_reset(OP_HOLD);
    step(1'b1, OP_JMP, 8'h07, 5'd0, 1'b0);
    irq = 1'b1;
    step(1'b1, OP_INC, 8'h00, 5'd0, 1'b0);
    irq = 1'b0;
    chk("irq_pc", pc, 8'hF0); chk("irq_sp", sp, 3'd1); chk("irq_fault", fault, 1'b0);
    step(1'b1, OP_RET, 8'h00, 5'd0, 1'b0);
    chk("irq_ret_pc", pc, 8'h08); chk("irq_ret_sp", sp, 3'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
